// File: rtl/map_pkg.sv
// Shared constants, FSM state encoding and row-address helper for the tile-map scheduler.
package map_pkg;

  localparam int         MAP_COLS  = 28;
  localparam int         MAP_ROWS  = 10;
  localparam int         V_LAST    = 524;
  localparam logic [4:0] TILE_NONE = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // y*28 as (y<<5) - (y<<2) in 9-bit unsigned arithmetic.
  function automatic logic [8:0] row_base(input logic [3:0] y);
    logic [8:0] w_y;
    w_y = {5'd0, y};
    return (w_y << 5) - (w_y << 2);
  endfunction

endpackage

// File: rtl/map_line_buf.sv
// Two-bank, 28-entry x 5-bit register line buffer: one write port, one combinational read port.
module map_line_buf (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic       i_wr_bank,
  input  logic [4:0] i_wr_col,
  input  logic [4:0] i_wr_data,
  input  logic       i_rd_bank,
  input  logic [4:0] i_rd_col,
  output logic [4:0] o_rd_data
);
  import map_pkg::*;

  logic [4:0] r_buf [2][MAP_COLS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < MAP_COLS; c++) begin
          r_buf[b][c] <= '0;
        end
      end
    end else if (i_wr_en && (i_wr_col < 5'(MAP_COLS))) begin
      r_buf[i_wr_bank][i_wr_col] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_rd_col < 5'(MAP_COLS)) o_rd_data = r_buf[i_rd_bank][i_rd_col];
  end

endmodule

// File: rtl/map_tile_sched.sv
// Tile-map scheduler: prefetches the next map row into a line-buffer bank during hblank
// and arbitrates game-logic tile writes into the layout memory between fetches.
module map_tile_sched (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       hblank,
  output logic [8:0] mem_addr,
  input  logic [4:0] mem_rdata,
  output logic       mem_we,
  output logic [4:0] mem_wdata,
  input  logic       wr_req,
  input  logic [4:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [4:0] wr_tile,
  output logic       wr_ack,
  output logic [4:0] tile_code,
  output logic       fetch_late,
  output logic [1:0] dbg_state
);
  import map_pkg::*;

  state_t     r_state;
  logic       r_hblank_d;
  logic [3:0] r_row;
  logic [4:0] r_col;

  logic       w_hb_rise;
  logic       w_trig;
  logic [3:0] w_trig_row;
  logic       w_wr_ok;
  logic       w_late_pos;
  logic       w_buf_we;
  logic [4:0] w_buf_col;
  logic [4:0] w_rd_data;

  assign w_hb_rise  = hblank & ~r_hblank_d;
  assign w_wr_ok    = (wr_x < 5'(MAP_COLS)) && (wr_y < 4'(MAP_ROWS));
  assign w_late_pos = (r_state == S_FETCH) && (DrawX == 10'd0) &&
                      (DrawY == {3'd0, r_row, 3'd0});
  assign dbg_state  = r_state;

  // Last scanline of a row band prefetches the next band; the frame's last line prefetches row 0.
  always_comb begin
    w_trig     = 1'b0;
    w_trig_row = 4'd0;
    if (w_hb_rise) begin
      if (DrawY == 10'(V_LAST)) begin
        w_trig = 1'b1;
      end else if ((DrawY[2:0] == 3'd7) && (DrawY[9:3] < 7'(MAP_ROWS - 1))) begin
        w_trig     = 1'b1;
        w_trig_row = DrawY[6:3] + 4'd1;
      end
    end
  end

  // wr_req/wr_ack: the requester holds wr_req and its fields stable until it sees wr_ack,
  // a single-cycle pulse in the WRITE cycle; wr_req must drop on the edge that ends that cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_hblank_d <= 1'b0;
      r_row      <= 4'd0;
      r_col      <= 5'd0;
      mem_addr   <= 9'd0;
      mem_we     <= 1'b0;
      mem_wdata  <= 5'd0;
      wr_ack     <= 1'b0;
      fetch_late <= 1'b0;
    end else begin
      r_hblank_d <= hblank;
      mem_we     <= 1'b0;
      wr_ack     <= 1'b0;
      mem_addr   <= 9'd0;
      if (w_late_pos || ((r_state == S_FETCH) && w_trig)) fetch_late <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state  <= S_FETCH;
            r_row    <= w_trig_row;
            r_col    <= 5'd0;
            mem_addr <= row_base(w_trig_row);
          end else if (wr_req) begin
            r_state   <= S_WRITE;
            wr_ack    <= 1'b1;
            mem_we    <= w_wr_ok;
            mem_wdata <= wr_tile;
            if (w_wr_ok) mem_addr <= row_base(wr_y) + {4'd0, wr_x};
          end
        end
        S_FETCH: begin
          // r_col counts issued addresses; data for column r_col-1 arrives this cycle.
          r_col <= r_col + 5'd1;
          if (r_col < 5'(MAP_COLS - 1)) mem_addr <= row_base(r_row) + 9'(r_col) + 9'd1;
          if (r_col == 5'(MAP_COLS)) begin
            r_state <= S_IDLE;
            r_col   <= 5'd0;
          end
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_buf_we  = (r_state == S_FETCH) && (r_col != 5'd0);
  assign w_buf_col = r_col - 5'd1;

  map_line_buf u_line_buf (
    .i_clk     (Clk),
    .i_rst_n   (Reset_n),
    .i_wr_en   (w_buf_we),
    .i_wr_bank (r_row[0]),
    .i_wr_col  (w_buf_col),
    .i_wr_data (mem_rdata),
    .i_rd_bank (DrawY[3]),
    .i_rd_col  (DrawX[7:3]),
    .o_rd_data (w_rd_data)
  );

  assign tile_code = ((DrawX < 10'(MAP_COLS * 8)) && (DrawY < 10'(MAP_ROWS * 8))) ?
                     w_rd_data : TILE_NONE;

endmodule

// File: tb/tb_map_tile_sched.sv
// Bench for map_tile_sched: directed scenarios plus randomized tile writes over compressed frames,
// checked every cycle against a time-window model of fetches and writes.
module tb_map_tile_sched;
  import map_pkg::*;

  localparam int H_TOTAL  = 264;
  localparam int HB_START = 228;

  logic       Clk;
  logic       Reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hblank;
  logic [8:0] mem_addr;
  logic [4:0] mem_rdata = 5'd0;
  logic       mem_we;
  logic [4:0] mem_wdata;
  logic       wr_req;
  logic [4:0] wr_x;
  logic [3:0] wr_y;
  logic [4:0] wr_tile;
  logic       wr_ack;
  logic [4:0] tile_code;
  logic       fetch_late;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] mem  [512];
  logic [4:0] mm   [512];
  logic [4:0] mbuf [2][28];

  int     cyc = 0;
  bit     m_fetch_on = 0;
  int     m_t0 = 0;
  int     m_row = 0;
  int     m_wr_cyc = -1;
  int     m_wx = 0, m_wy = 0, m_wt = 0;
  bit     m_prev_hb = 0;
  bit     m_late = 0;
  int     exp_addr = 0;
  bit     exp_we = 0;
  bit     exp_ack = 0;
  int     exp_wdata = 0;
  state_t exp_state = S_IDLE;

  bit chk_en = 0;
  bit mon_on = 0;
  int fetch_cyc = 0;
  int addr_q[$];

  map_tile_sched dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .hblank     (hblank),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .wr_req     (wr_req),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_tile    (wr_tile),
    .wr_ack     (wr_ack),
    .tile_code  (tile_code),
    .fetch_late (fetch_late),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- layout memory (one-cycle read latency) ----------------
  initial begin
    for (int a = 0; a < 512; a++) mem[a] = (a < 280) ? 5'((a % 28) % 20) : 5'd0;
    forever begin
      @(posedge Clk);
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  initial begin
    int  k, trow;
    bit  rise, trig, in_fetch, in_write;
    for (int a = 0; a < 512; a++) mm[a] = (a < 280) ? 5'((a % 28) % 20) : 5'd0;
    for (int b = 0; b < 2; b++) for (int c = 0; c < 28; c++) mbuf[b][c] = 5'd0;
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        m_fetch_on = 0; m_wr_cyc = -1; m_prev_hb = 0; m_late = 0;
        for (int b = 0; b < 2; b++) for (int c = 0; c < 28; c++) mbuf[b][c] = 5'd0;
        exp_addr = 0; exp_we = 0; exp_ack = 0; exp_state = S_IDLE;
      end else begin
        rise = hblank && !m_prev_hb;
        trig = 0; trow = 0;
        if (rise && int'(DrawY) == 524) begin
          trig = 1; trow = 0;
        end else if (rise && int'(DrawY) % 8 == 7 && int'(DrawY) / 8 + 1 < 10) begin
          trig = 1; trow = int'(DrawY) / 8 + 1;
        end
        in_fetch = m_fetch_on;
        in_write = (cyc == m_wr_cyc);
        if (in_fetch) begin
          k = cyc - m_t0;
          if (k >= 1) mbuf[m_row % 2][k - 1] = mm[m_row * 28 + k - 1];
          if ((int'(DrawX) == 0 && int'(DrawY) == 8 * m_row) || trig) m_late = 1;
          if (k == 28) m_fetch_on = 0;
        end else if (!in_write) begin
          if (trig) begin
            m_fetch_on = 1; m_t0 = cyc + 1; m_row = trow;
          end else if (wr_req) begin
            m_wr_cyc = cyc + 1; m_wx = int'(wr_x); m_wy = int'(wr_y); m_wt = int'(wr_tile);
            if (m_wx < 28 && m_wy < 10) mm[m_wy * 28 + m_wx] = 5'(m_wt);
          end
        end
        m_prev_hb = hblank;
        cyc++;
        exp_addr = 0; exp_we = 0; exp_ack = 0; exp_state = S_IDLE;
        if (m_fetch_on) begin
          exp_state = S_FETCH;
          if (cyc - m_t0 < 28) exp_addr = m_row * 28 + (cyc - m_t0);
        end
        if (cyc == m_wr_cyc) begin
          exp_state = S_WRITE;
          exp_ack   = 1;
          if (m_wx < 28 && m_wy < 10) begin
            exp_we = 1; exp_addr = m_wy * 28 + m_wx; exp_wdata = m_wt;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  initial begin
    int exp_tile;
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        exp_tile = (int'(DrawX) < 224 && int'(DrawY) < 80) ?
                   int'(mbuf[(int'(DrawY) / 8) % 2][int'(DrawX) / 8]) : 31;
        check("mem_addr", int'(mem_addr), exp_addr);
        check("mem_we", int'(mem_we), int'(exp_we));
        check("wr_ack", int'(wr_ack), int'(exp_ack));
        check("state", int'(dbg_state), int'(exp_state));
        check("fetch_late", int'(fetch_late), int'(m_late));
        check("tile_code", int'(tile_code), exp_tile);
        if (exp_we) check("mem_wdata", int'(mem_wdata), exp_wdata);
      end
      if (mon_on && dbg_state == 2'(S_FETCH)) begin
        fetch_cyc++;
        addr_q.push_back(int'(mem_addr));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    logic was_ack;
    was_ack = wr_ack;
    @(posedge Clk);
    #1;
    if (was_ack) wr_req = 1'b0;
  endtask

  task automatic set_px(input int x, input int y, input bit h);
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    hblank = h;
    step();
  endtask

  task automatic run_line(input int y, input bit rnd);
    for (int x = 0; x < H_TOTAL; x++) begin
      if (rnd && !wr_req && $urandom_range(0, 99) < 3) begin
        wr_x    = 5'($urandom_range(0, 31));
        wr_y    = 4'($urandom_range(0, 15));
        wr_tile = 5'($urandom_range(0, 31));
        wr_req  = 1'b1;
      end
      set_px(x, y, x >= HB_START);
    end
  endtask

  task automatic check_fetch(input string name, input int base);
    check({name, "_cycles"}, fetch_cyc, 29);
    check({name, "_naddr"}, addr_q.size(), 29);
    if (addr_q.size() >= 28) begin
      for (int i = 0; i < 28; i++) check({name, "_addr"}, addr_q[i], base + i);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ack_n, ack_at, got_addr, got_we, got_wd;
    Reset_n = 1'b0; DrawX = 10'd0; DrawY = 10'd0; hblank = 1'b0;
    wr_req = 1'b0; wr_x = 5'd0; wr_y = 4'd0; wr_tile = 5'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_wr_ack", int'(wr_ack), 0);
    check("rst_late", int'(fetch_late), 0);
    check("rst_state", int'(dbg_state), int'(S_IDLE));
    check("rst_tile_in", int'(tile_code), 0);
    DrawX = 10'd230;
    #1;
    check("rst_tile_out", int'(tile_code), 31);
    DrawX = 10'd0;
    chk_en = 1;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Row 3 fetch on the last line of band 2.
    addr_q.delete(); fetch_cyc = 0; mon_on = 1;
    run_line(23, 0);
    mon_on = 0;
    check_fetch("row3", 84);
    set_px(8, 24, 0);
    check("row3_x8", int'(tile_code), 1);
    set_px(15, 24, 0);
    check("row3_x15", int'(tile_code), 1);
    set_px(16, 24, 0);
    check("row3_x16", int'(tile_code), 2);

    // Frame start: row 0 prefetched on the last scanline.
    run_line(524, 0);
    set_px(104, 0, 0);
    check("row0_x104", int'(tile_code), 13);
    set_px(230, 0, 0);
    check("row0_x230", int'(tile_code), 31);

    // Write request on the trigger cycle: fetch first, write two cycles after it ends.
    set_px(200, 524, 0);
    wr_x = 5'd13; wr_y = 4'd0; wr_tile = 5'd20; wr_req = 1'b1;
    set_px(228, 524, 1);
    ack_n = 0; ack_at = -1; got_addr = -1; got_we = -1; got_wd = -1;
    for (int i = 1; i <= 40; i++) begin
      if (wr_ack) begin
        ack_n++;
        if (ack_at < 0) begin
          ack_at = i; got_addr = int'(mem_addr); got_we = int'(mem_we); got_wd = int'(mem_wdata);
        end
      end
      set_px(229 + i, 524, 1);
    end
    check("arb_ack_count", ack_n, 1);
    check("arb_ack_cycle", ack_at, 31);
    check("arb_addr", got_addr, 13);
    check("arb_we", got_we, 1);
    check("arb_wdata", got_wd, 20);
    run_line(524, 0);
    set_px(104, 0, 0);
    check("row0_written", int'(tile_code), 20);

    // Out-of-range write: acked, no memory write.
    wr_x = 5'd28; wr_y = 4'd2; wr_tile = 5'd7; wr_req = 1'b1;
    set_px(40, 24, 0);
    ack_n = 0; got_we = -1;
    for (int i = 0; i < 10; i++) begin
      if (wr_ack) begin
        ack_n++; got_we = int'(mem_we);
      end
      set_px(41 + i, 24, 0);
    end
    check("oor_ack_count", ack_n, 1);
    check("oor_we", got_we, 0);
    check("oor_mem84", int'(mem[84]), 0);

    // Late fetch: row 2 display begins while its fetch is still running.
    set_px(228, 15, 0);
    set_px(229, 15, 1);
    for (int i = 0; i < 4; i++) set_px(230 + i, 15, 1);
    set_px(0, 16, 0);
    for (int i = 0; i < 30; i++) set_px(1 + i, 16, 0);
    check("late_set", int'(fetch_late), 1);
    for (int i = 0; i < 20; i++) set_px(40 + i, 16, 0);
    check("late_sticky", int'(fetch_late), 1);

    // Reset mid-fetch at column 10, then a clean refetch.
    set_px(200, 524, 0);
    set_px(228, 524, 1);
    for (int i = 0; i < 10; i++) set_px(229 + i, 524, 1);
    #1;
    Reset_n = 1'b0;
    #1;
    check("rstf_state", int'(dbg_state), int'(S_IDLE));
    check("rstf_addr", int'(mem_addr), 0);
    check("rstf_late", int'(fetch_late), 0);
    DrawY = 10'd0; DrawX = 10'd104; hblank = 1'b0;
    #1;
    check("rstf_tile", int'(tile_code), 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    addr_q.delete(); fetch_cyc = 0; mon_on = 1;
    run_line(524, 0);
    mon_on = 0;
    check_fetch("refetch", 0);
    set_px(104, 0, 0);
    check("refetch_x104", int'(tile_code), 20);

    // Randomized tile writes over two compressed frames.
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < 80; y++) run_line(y, 1);
      run_line(524, 1);
    end
    for (int i = 0; i < 100 && wr_req; i++) set_px(0, 200, 0);
    check("drain_req", int'(wr_req), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/map_tile_sched.md
MAP_TILE_SCHED -- requirements
Module: map_tile_sched

Interface
REQ-001 Parameters: MAP_COLS = 28, tiles per map row; MAP_ROWS = 10, tile rows; V_LAST = 524, last scanline of frame; TILE_NONE = 5'd31, code for outside the map.
REQ-002 Clk  in  1  pixel clock; all state advances on the rising edge.
REQ-003 Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 DrawX  in  10  current pixel column.
REQ-005 DrawY  in  10  current scanline.
REQ-006 hblank  in  1  high during horizontal blanking.
REQ-007 mem_addr  out  9  layout memory address = y*MAP_COLS + x.
REQ-008 mem_rdata  in  5  layout read data, valid exactly 1 cycle after mem_addr.
REQ-009 mem_we  out  1  layout write strobe.
REQ-010 mem_wdata  out  5  layout write data.
REQ-011 wr_req  in  1  game-logic tile update request; held high until acked.
REQ-012 wr_x  in  5  tile column of the update.
REQ-013 wr_y  in  4  tile row of the update.
REQ-014 wr_tile  in  5  new tile code.
REQ-015 wr_ack  out  1  single-cycle acknowledge of an update.
REQ-016 tile_code  out  5  tile code for the current pixel.
REQ-017 fetch_late  out  1  sticky error flag.

Function
REQ-018 FSM states: IDLE, FETCH, WRITE; reset state IDLE.
REQ-019 Fetch trigger is the first cycle of the hblank rising edge, under either condition:
- DrawY[2:0]==7 and (DrawY>>3)+1 < MAP_ROWS, giving target row (DrawY>>3)+1;
- DrawY==V_LAST, giving target row 0.
REQ-020 A trigger in IDLE enters FETCH, with priority over a pending wr_req in the same cycle.
REQ-021 FETCH issues 28 consecutive read addresses, columns 0..27 of the target row, one per cycle.
REQ-022 Each returned word is written one cycle later into line-buffer bank (target row LSB), column index matching.
REQ-023 The FSM returns to IDLE after the last data word is captured; total 29 cycles.
REQ-024 Row r is displayed from bank r[0], so no explicit swap is needed.
REQ-025 tile_code is combinational from the bank registers:
- = bank[(DrawY>>3)[0]][DrawX>>3] when DrawX < 224 and DrawY < 80;
- otherwise TILE_NONE.
REQ-026 In IDLE with wr_req high and no trigger, the FSM enters WRITE.
REQ-027 WRITE lasts one cycle:
- mem_we = 1, mem_addr = wr_y*28 + wr_x, mem_wdata = wr_tile, wr_ack = 1;
- next state IDLE.
REQ-028 If wr_x > 27 or wr_y > 9, WRITE asserts wr_ack with mem_we = 0 and no memory change.
REQ-029 A wr_req arriving during FETCH waits; it is acked 2 cycles after FETCH ends at the earliest.
REQ-030 Written tiles are not reflected in already-fetched banks; they become visible at the next fetch of that row.
REQ-031 fetch_late sets if the FSM is in FETCH when DrawX==0 and DrawY equals 8 × target row.
REQ-032 fetch_late also sets if a trigger occurs while in FETCH; that trigger is ignored.
REQ-033 fetch_late clears only on reset.
REQ-034 mem_we = 0 and wr_ack = 0 in every state other than WRITE.
REQ-035 mem_addr = 0 when neither fetching nor writing.

Reset
REQ-036 Reset_n low asynchronously forces:
- state IDLE, all line-buffer entries 0;
- mem_we = 0, wr_ack = 0, fetch_late = 0, mem_addr = 0;
- the fetch column counter to 0.
REQ-037 Reset mid-FETCH abandons the row; the in-flight read is discarded; the next trigger refetches.
REQ-038 Reset mid-WRITE suppresses mem_we immediately; wr_req must be held to retry.
REQ-039 Exit from reset takes effect on the first rising Clk edge after Reset_n goes high.

Structure
REQ-040 Package map_pkg holds MAP_COLS, MAP_ROWS, V_LAST, TILE_NONE and the FSM state enum.
REQ-041 The two-bank 28x5-bit register buffer is a sub-module, map_line_buf:
- one write port: bank, column, data, enable;
- one combinational read port: bank, column.
REQ-042 Address arithmetic is 9-bit unsigned; y*28 is implemented as (y<<5) - (y<<2).

Verification
REQ-043 Row fetch: memory row 3 = tiles 0..27 with value = column mod 20; hblank rise at DrawY=23 -> 28 reads at addr 84..111, FETCH 29 cycles; at DrawY=24, DrawX=8..15 -> tile_code = 1.
REQ-044 Frame start: DrawY=524 hblank rise -> fetch row 0 into bank 0; DrawY=0, DrawX=104 -> tile_code = mem[13]; DrawX=230 -> 31.
REQ-045 Write arbitration: wr_req (x=13, y=0, tile=20) asserted on the trigger cycle -> FETCH runs first; WRITE follows with mem_addr = 13, mem_we = 1 for one cycle; wr_ack one cycle; next frame row 0 shows 20 at DrawX=104.
REQ-046 Out-of-range: wr_x=28, wr_y=2 -> wr_ack = 1, mem_we = 0, memory unchanged.
REQ-047 Late fetch: stall the trigger until DrawX=0 of the target row is reached mid-FETCH -> fetch_late = 1 and remains set until Reset_n low.
REQ-048 Reset mid-FETCH at column 10 -> state IDLE, buffer all 0, tile_code = 0 inside the map; the next trigger completes 28 reads normally.
